priority_serializer: RTL and testbench
======================================

// Module: priority_serializer
// PURPOSE
//   Parametrised successor to the fixed 8-bit priority encoder.
//   Accepts a W-bit request vector over a valid/ready handshake.
//   Emits the index of every set bit, one per output beat, in priority order.
//   Sits between request collectors (irq/event vectors) and single-index
//   consumers that need every pending request serviced, not only the winner.
// PARAMETERS
//   W          8   request vector width, >= 2
//   MSB_FIRST  1   1: highest set bit has priority; 0: lowest set bit has priority
//   IW         -   localparam = $clog2(W), width of out_idx
// PORTS
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous, active-high reset
//   in_valid   in   1    in_req is valid
//   in_ready   out  1    block can capture a new vector
//   in_req     in   W    request vector
//   out_valid  out  1    out_idx/out_empty are valid
//   out_ready  in   1    consumer accepts the current beat
//   out_idx    out  IW   index of the current highest-priority pending bit
//   out_empty  out  1    beat belongs to an all-zero vector; out_idx = 0
//   out_last   out  1    final beat of the vector (PRIO_SER_LAST_EN only)
// BEHAVIOUR
//   - Single clock clk. Synchronous active-high rst.
//   - Reset values: state=IDLE, pend=0, in_ready=1, out_valid=0, out_idx=0,
//     out_empty=0, out_last=0.
//   - All outputs are decoded from registers only.
//     There is no combinational path from any input to any output.
//   - FSM states:
//       IDLE  : in_ready=1, out_valid=0.
//               If in_valid && in_req!=0: pend<=in_req; next state DRAIN.
//               If in_valid && in_req==0: next state ZERO.
//       DRAIN : out_valid=1; out_idx=encode(pend), selected by MSB_FIRST.
//               If out_ready: clear bit out_idx in pend.
//               If pend had exactly one bit set, next state IDLE; else stay in DRAIN.
//       ZERO  : out_valid=1, out_empty=1, out_idx=0.
//               If out_ready, next state IDLE.
//   - Latency: first beat is valid on the cycle after the input handshake.
//   - Throughput: one index per cycle while out_ready=1.
//   - Timing of vectors:
//       A vector with k set bits occupies k output cycles plus 1 IDLE cycle.
//       in_ready is high only in IDLE. A new vector is never merged into pend.
//   - Backpressure: while out_valid=1 && !out_ready, out_idx, out_empty and
//     out_last hold stable. out_valid never drops without a handshake.
//   - in_req is sampled only on the in_valid && in_ready cycle.
//     Later changes to in_req are ignored.
//   - rst asserted mid-vector: the remaining pend bits are discarded.
//     Outputs take their reset values on the next edge.
// CONFIGURATION
//   PRIO_SER_LAST_EN defined:
//     out_last port exists.
//     out_last=1 when pend has one bit set (DRAIN) or in ZERO; else 0.
//   PRIO_SER_LAST_EN undefined:
//     out_last port and its logic are absent. All other behaviour is identical.
// STRUCTURE
//   - Package prio_ser_pkg:
//       state enum typedef {IDLE, DRAIN, ZERO}
//       2-bit state encoding constants
//   - Sub-module prio_enc_comb #(W, MSB_FIRST):
//       pure combinational encoder: vec -> idx and any flag
//       reused by this block and future arbiters
// TESTING (W=8 unless noted)
//   1. rst held 2 cycles -> in_ready=1, out_valid=0, out_idx=0.
//   2. MSB_FIRST=1, in_req=8'b1010_0110, out_ready=1:
//        idx 7,5,2,1 on 4 consecutive cycles; out_last on idx 1; in_ready=1 after.
//   3. MSB_FIRST=0, same vector -> idx 1,2,5,7.
//   4. in_req=8'h00 -> one beat, out_empty=1, out_idx=0; in_ready=1 next cycle.
//   5. in_req=8'hFF, out_ready low for 3 cycles on idx 7:
//        idx holds 7; then 6..0 follow.
//      in_valid pulsed during drain -> in_ready=0, vector not captured.
//   6. rst mid-drain after idx 7 of 8'h81 -> out_valid=0 next cycle.
//      Idx 0 is never emitted.

Source files
------------

// File: rtl/prio_ser_pkg.sv
// Shared types for the priority serializer: FSM state encoding and state enum.
// Latency: none (declarations only).
// Backpressure: not applicable.
package prio_ser_pkg;

   // Explicit 2-bit codes so the state register width never depends on tool enum sizing.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_ZERO  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      DRAIN = ST_DRAIN,
      ZERO  = ST_ZERO
   } state_t;

endpackage

// File: rtl/prio_enc_comb.sv
// Pure combinational priority encoder: vec -> index of winning set bit, plus any-bit flag.
// Latency: combinational, zero cycles.
// Backpressure: not applicable; idx is 0 when vec is all zero.
module prio_enc_comb #(
   parameter int W         = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int IW       = $clog2(W)
) (
   input  logic [W-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan in reverse priority order so the last hit seen is the winner.
   always_comb begin
      idx = '0;
      any = |vec;
      if (MSB_FIRST) begin
         for (int i = 0; i < W; i++) begin
            if (vec[i]) idx = IW'(i);
         end
      end else begin
         for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/priority_serializer.sv
// Captures a W-bit request vector and emits each set bit's index, one per beat, in priority order.
// Latency: first beat one cycle after the input handshake; k set bits take k beats plus one IDLE cycle.
// Backpressure: out_ready low freezes the current beat; in_ready is high only in IDLE. Optional out_last via PRIO_SER_LAST_EN.
module priority_serializer #(
   parameter int W         = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int IW       = $clog2(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_req,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_idx,
   output logic          out_empty
`ifdef PRIO_SER_LAST_EN
   ,
   output logic          out_last
`endif
);

   import prio_ser_pkg::*;

   state_t        state;
   state_t        state_nxt;
   logic [W-1:0]  pend;
   logic [W-1:0]  pend_clr;
   logic [IW-1:0] enc_idx;
   logic          enc_any;
   logic          pend_single;
   logic          in_hs;

   // Winner of the pending vector; every output is decoded from pend and state only.
   prio_enc_comb #(
      .W         (W),
      .MSB_FIRST (MSB_FIRST)
   ) u_enc (
      .vec (pend),
      .idx (enc_idx),
      .any (enc_any)
   );

   // Pending vector with the current winner removed; empty result means this is the final beat.
   assign pend_clr    = pend & ~(W'(1) << enc_idx);
   assign pend_single = enc_any && (pend_clr == '0);
   assign in_hs       = in_valid && (state == IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: capture in IDLE, drain one bit per accepted beat, single beat for zero vectors.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) state_nxt = (in_req != '0) ? DRAIN : ZERO;
         end
         DRAIN: begin
            // pend can't be empty here; returning to IDLE keeps the FSM from wedging if it ever is.
            if (!enc_any)                       state_nxt = IDLE;
            else if (out_ready && pend_single)  state_nxt = IDLE;
         end
         ZERO: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pending-bit register: loaded only on the input handshake, one bit cleared per accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
      end else if (in_hs) begin
         pend <= in_req;
      end else if ((state == DRAIN) && out_ready) begin
         pend <= pend_clr;
      end
   end

   // Output decode from registered state and pend; no input reaches an output combinationally.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_idx   = '0;
      out_empty = 1'b0;
`ifdef PRIO_SER_LAST_EN
      out_last  = 1'b0;
`endif
      case (state)
         IDLE: begin
            in_ready = 1'b1;
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_idx   = enc_idx;
`ifdef PRIO_SER_LAST_EN
            out_last  = pend_single;
`endif
         end
         ZERO: begin
            out_valid = 1'b1;
            out_empty = 1'b1;
`ifdef PRIO_SER_LAST_EN
            out_last  = 1'b1;
`endif
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_priority_serializer.sv
// Bench for priority_serializer: MSB-first and LSB-first instances share one stimulus stream.
// A queue model of pending beats checks both instances every cycle; directed cases pin literal values.
module tb_priority_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_req = '0;
   logic         out_ready = 1'b1;

   logic         hi_in_ready, hi_out_valid, hi_out_empty;
   logic [2:0]   hi_out_idx;
   logic         lo_in_ready, lo_out_valid, lo_out_empty;
   logic [2:0]   lo_out_idx;
`ifdef PRIO_SER_LAST_EN
   logic         hi_out_last, lo_out_last;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   priority_serializer #(.W(W), .MSB_FIRST(1'b1)) dut_hi (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (hi_in_ready),
      .in_req    (in_req),
      .out_valid (hi_out_valid),
      .out_ready (out_ready),
      .out_idx   (hi_out_idx),
      .out_empty (hi_out_empty)
`ifdef PRIO_SER_LAST_EN
      ,
      .out_last  (hi_out_last)
`endif
   );

   priority_serializer #(.W(W), .MSB_FIRST(1'b0)) dut_lo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (lo_in_ready),
      .in_req    (in_req),
      .out_valid (lo_out_valid),
      .out_ready (out_ready),
      .out_idx   (lo_out_idx),
      .out_empty (lo_out_empty)
`ifdef PRIO_SER_LAST_EN
      ,
      .out_last  (lo_out_last)
`endif
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the list of beats still owed for the current vector.
   // Empty list = idle. A beat value of -1 stands for the all-zero-vector beat.
   int q_hi[$];
   int q_lo[$];
   bit mdl_on = 1'b0;

   task automatic check_dut(input string tag, input logic ir, input logic ov,
                            input logic [2:0] oi, input logic oe, input int hd, input int sz);
      chk({tag, ".in_ready"},  int'(ir), int'(sz == 0));
      chk({tag, ".out_valid"}, int'(ov), int'(sz != 0));
      chk({tag, ".out_idx"},   int'(oi), (sz != 0 && hd >= 0) ? hd : 0);
      chk({tag, ".out_empty"}, int'(oe), int'(sz != 0 && hd < 0));
   endtask

   // Compare outputs against the model mid-cycle, then advance the model by what the next edge sees.
   always @(negedge clk) begin
      if (mdl_on) begin
         check_dut("hi", hi_in_ready, hi_out_valid, hi_out_idx, hi_out_empty,
                   (q_hi.size() != 0) ? q_hi[0] : 0, q_hi.size());
         check_dut("lo", lo_in_ready, lo_out_valid, lo_out_idx, lo_out_empty,
                   (q_lo.size() != 0) ? q_lo[0] : 0, q_lo.size());
`ifdef PRIO_SER_LAST_EN
         chk("hi.out_last", int'(hi_out_last), int'(q_hi.size() == 1));
         chk("lo.out_last", int'(lo_out_last), int'(q_lo.size() == 1));
`endif
      end
      if (rst) begin
         q_hi.delete();
         q_lo.delete();
         mdl_on = 1'b1;
      end else if (mdl_on) begin
         if (q_hi.size() == 0) begin
            if (in_valid) begin
               if (in_req == '0) begin
                  q_hi.push_back(-1);
                  q_lo.push_back(-1);
               end else begin
                  for (int b = W - 1; b >= 0; b--) begin
                     if (in_req[b]) begin
                        q_hi.push_back(b);
                        q_lo.push_front(b);
                     end
                  end
               end
            end
         end else if (out_ready) begin
            void'(q_hi.pop_front());
            void'(q_lo.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one vector, waiting a bounded time for in_ready; returns when the first beat is visible.
   task automatic send(input logic [W-1:0] v);
      int n = 0;
      while (!hi_in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!hi_in_ready) chk("send_wait_in_ready", 0, 1);
      in_valid = 1'b1;
      in_req   = v;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int e_hi[4] = '{7, 5, 2, 1};
      int e_lo[4] = '{1, 2, 5, 7};
      logic [W-1:0] r;

      // Reset held two cycles.
      rst = 1'b1;
      tick();
      tick();
      chk("rst.in_ready",  int'(hi_in_ready), 1);
      chk("rst.out_valid", int'(hi_out_valid), 0);
      chk("rst.out_idx",   int'(hi_out_idx), 0);
      rst = 1'b0;
      tick();

      // 8'b1010_0110 with out_ready high: both priority orders.
      out_ready = 1'b1;
      send(8'b1010_0110);
      for (int i = 0; i < 4; i++) begin
         chk("a6.hi_idx", int'(hi_out_idx), e_hi[i]);
         chk("a6.lo_idx", int'(lo_out_idx), e_lo[i]);
`ifdef PRIO_SER_LAST_EN
         chk("a6.hi_last", int'(hi_out_last), int'(i == 3));
`endif
         if (i < 3) tick();
      end
      tick();
      chk("a6.in_ready_after", int'(hi_in_ready), 1);
      chk("a6.out_valid_after", int'(hi_out_valid), 0);

      // All-zero vector: one empty beat.
      send(8'h00);
      chk("zero.out_valid", int'(hi_out_valid), 1);
      chk("zero.out_empty", int'(hi_out_empty), 1);
      chk("zero.out_idx",   int'(hi_out_idx), 0);
      tick();
      chk("zero.in_ready_next", int'(hi_in_ready), 1);

      // 8'hFF with a 3-cycle stall on idx 7 and an in_valid pulse during the drain.
      out_ready = 1'b0;
      send(8'hFF);
      for (int i = 0; i < 3; i++) begin
         chk("ff.stall_idx", int'(hi_out_idx), 7);
         chk("ff.stall_in_ready", int'(hi_in_ready), 0);
         in_valid = (i == 1);
         in_req   = 8'h0F;
         tick();
      end
      in_valid = 1'b0;
      chk("ff.hold_idx", int'(hi_out_idx), 7);
      out_ready = 1'b1;
      for (int k = 6; k >= 0; k--) begin
         tick();
         chk("ff.drain_idx", int'(hi_out_idx), k);
      end
      tick();
      chk("ff.in_ready_after", int'(hi_in_ready), 1);
      tick();
      chk("ff.pulse_not_captured", int'(hi_out_valid), 0);

      // Reset mid-drain of 8'h81 after idx 7 is shown.
      send(8'h81);
      chk("r81.first_idx", int'(hi_out_idx), 7);
      rst = 1'b1;
      tick();
      chk("r81.out_valid_after_rst", int'(hi_out_valid), 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("r81.no_idx0", int'(hi_out_valid), 0);
      end

      // Randomized traffic, checked by the model every cycle.
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 99) == 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 7))
            0:       r = '0;
            1:       r = W'(1) << $urandom_range(0, W - 1);
            default: r = W'($urandom);
         endcase
         in_req = r;
         tick();
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (12) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
